// File: rtl/audio_sample_arbiter.sv
// audio_sample_arbiter: round-robin speaker ownership with a sample-rate tick; define AUDIO_SAMPLE_ARBITER_MIX_EN to build a saturating mixer instead
module audio_sample_arbiter #(
  parameter int clk_mhz        = 50,
  parameter int sample_rate_hz = 48000,
  parameter int n_src          = 4,
  parameter int w_sample       = 16,
  parameter int release_ticks  = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [n_src-1:0]            src_valid,
  input  logic [n_src*w_sample-1:0]   src_sample,
  output logic [n_src-1:0]            src_ready,
  output logic [w_sample-1:0]         sound,
  output logic                        sound_valid,
  output logic                        sample_tick,
  output logic                        owned,
  output logic [$clog2(n_src)-1:0]    owner_id
);
  localparam int DIV = clk_mhz * 1000000 / sample_rate_hz;
  localparam int TW  = $clog2(DIV);
  localparam int IW  = $clog2(n_src);
  logic [TW-1:0] tick_cnt;
  assign sample_tick = tick_cnt == TW'(DIV - 1);
  // sample-rate divider, wraps after DIV cycles
  always_ff @(posedge clk)
    tick_cnt <= !rst_n || sample_tick ? '0 : tick_cnt + 1'b1;
`ifdef AUDIO_SAMPLE_ARBITER_MIX_EN
  localparam int SW = w_sample + IW;
  logic [SW-1:0]       sum;
  logic [w_sample-1:0] mix;
  logic [IW-1:0]       low;
  assign src_ready = rst_n && sample_tick ? src_valid : '0;
  // sign-extend and sum every valid sample, then clamp to the output range
  always_comb begin
    sum = '0;
    low = '0;
    for (int i = n_src - 1; i >= 0; i--)
      if (src_valid[i]) begin
        sum = sum + {{IW{src_sample[i*w_sample+w_sample-1]}}, src_sample[i*w_sample +: w_sample]};
        low = IW'(i);
      end
    mix = (&sum[SW-1:w_sample-1] || ~|sum[SW-1:w_sample-1]) ? sum[w_sample-1:0]
        : {sum[SW-1], {(w_sample-1){~sum[SW-1]}}};
  end
  // register the mix and the accepted-source summary on each tick
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sound       <= '0;
      sound_valid <= 1'b0;
      owned       <= 1'b0;
      owner_id    <= '0;
    end else begin
      sound_valid <= sample_tick;
      if (sample_tick) begin
        sound    <= mix;
        owned    <= |src_valid;
        owner_id <= low;
      end
    end
  end
`else
  typedef enum logic {IDLE, OWNED} state_t;
  localparam int UW = $clog2(release_ticks + 1);
  state_t        state, state_n;
  logic [UW-1:0] underrun_cnt;
  logic [IW-1:0] last_owner, pick, sel;
  logic          found;
  assign sel   = state == IDLE ? pick : owner_id;
  assign owned = state == OWNED;
  // round-robin search starting just after the last owner; lowest offset wins
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = n_src; k >= 1; k--)
      if (src_valid[IW'((int'(last_owner) + k) % n_src)]) begin
        found = 1'b1;
        pick  = IW'((int'(last_owner) + k) % n_src);
      end
  end
  // ready decode and ownership transitions, only on tick cycles outside reset
  always_comb begin
    state_n   = state;
    src_ready = '0;
    if (rst_n && sample_tick) begin
      if (state == IDLE ? found : src_valid[owner_id]) src_ready[sel] = 1'b1;
      if (state == IDLE && found) state_n = OWNED;
      if (state == OWNED && !src_valid[owner_id] && underrun_cnt == UW'(release_ticks - 1)) state_n = IDLE;
    end
  end
  // state register
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : state_n;
  // output sample and ownership bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sound        <= '0;
      sound_valid  <= 1'b0;
      owner_id     <= '0;
      last_owner   <= IW'(n_src - 1);
      underrun_cnt <= '0;
    end else begin
      sound_valid <= sample_tick;
      if (sample_tick) begin
        sound <= |src_ready ? src_sample[sel*w_sample +: w_sample] : '0;
        if (state == IDLE && found) begin
          owner_id     <= pick;
          last_owner   <= pick;
          underrun_cnt <= '0;
        end else if (state == OWNED)
          underrun_cnt <= src_valid[owner_id] ? '0
                        : underrun_cnt == UW'(release_ticks) ? underrun_cnt : underrun_cnt + 1'b1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_audio_sample_arbiter.sv
// tb_audio_sample_arbiter: directed checks of divider, ownership, release, reset and optional mixer
module tb_audio_sample_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  src_valid;
  logic [63:0] src_sample;
  logic [3:0]  src_ready;
  logic [15:0] sound;
  logic        sound_valid, sample_tick, owned;
  logic [1:0]  owner_id;
  int checks = 0;
  int errors = 0;

  audio_sample_arbiter #(
    .clk_mhz(1), .sample_rate_hz(100000), .n_src(4), .w_sample(16), .release_ticks(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_sample(src_sample),
    .src_ready(src_ready), .sound(sound), .sound_valid(sound_valid),
    .sample_tick(sample_tick), .owned(owned), .owner_id(owner_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic wait_tick();
    int n = 0;
    while (!sample_tick && n < 25) begin
      @(negedge clk);
      n++;
    end
    if (!sample_tick) check("tick_timeout", 0, 1);
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    src_valid = '0;
    src_sample = '0;
    repeat (5) @(posedge clk);
    next();
    check("rst_sound", sound, 0);
    check("rst_owned", owned, 0);
    check("rst_svalid", sound_valid, 0);
    check("rst_owner", owner_id, 0);
    check("rst_tick", sample_tick, 0);
    rst_n = 1'b1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      check($sformatf("tick_c%0d", cyc), sample_tick, cyc % 10 == 0);
      check($sformatf("sv_c%0d", cyc), sound_valid, cyc == 11 || cyc == 21);
      if (cyc == 11) check("idle_sound", sound, 0);
      next();
    end
`ifdef AUDIO_SAMPLE_ARBITER_MIX_EN
    src_valid = 4'b0011;
    src_sample[0 +: 16] = 16'h7000;
    src_sample[16 +: 16] = 16'h2000;
    wait_tick();
    check("mix_ready", src_ready, 4'b0011);
    next();
    check("mix_pos_sat", sound, 16'h7FFF);
    check("mix_owned", owned, 1);
    check("mix_owner", owner_id, 0);
    src_sample[0 +: 16] = 16'h9000;
    src_sample[16 +: 16] = 16'hA000;
    wait_tick();
    next();
    check("mix_neg_sat", sound, 16'h8000);
    src_valid = 4'b1010;
    src_sample[16 +: 16] = 16'h0100;
    src_sample[48 +: 16] = 16'hFF00;
    wait_tick();
    check("mix_ready2", src_ready, 4'b1010);
    next();
    check("mix_sum", sound, 16'h0000);
    check("mix_owner_low", owner_id, 1);
    src_valid = '0;
    wait_tick();
    next();
    check("mix_none_owned", owned, 0);
    check("mix_none_sound", sound, 0);
`else
    src_valid = 4'b0100;
    src_sample[32 +: 16] = 16'h1234;
    check("rdy_notick", src_ready, 0);
    wait_tick();
    check("grant_ready", src_ready, 4'b0100);
    next();
    check("grant_sound", sound, 16'h1234);
    check("grant_sv", sound_valid, 1);
    check("grant_owned", owned, 1);
    check("grant_owner", owner_id, 2);
    check("grant_rdy_off", src_ready, 0);
    src_valid = 4'b0101;
    src_sample[0 +: 16] = 16'h1111;
    src_sample[32 +: 16] = 16'h2222;
    for (int t = 0; t < 2; t++) begin
      wait_tick();
      check($sformatf("excl_ready%0d", t), src_ready, 4'b0100);
      next();
      check($sformatf("excl_sound%0d", t), sound, 16'h2222);
      check($sformatf("excl_owner%0d", t), owner_id, 2);
    end
    src_valid = 4'b0000;
    wait_tick();
    check("ur1_ready", src_ready, 0);
    next();
    check("ur1_sound", sound, 0);
    check("ur1_sv", sound_valid, 1);
    check("ur1_owned", owned, 1);
    wait_tick();
    next();
    check("ur2_sound", sound, 0);
    check("ur2_owned", owned, 0);
    src_valid = 4'b1001;
    src_sample[48 +: 16] = 16'h3333;
    wait_tick();
    check("rr_ready", src_ready, 4'b1000);
    next();
    check("rr_owner", owner_id, 3);
    check("rr_sound", sound, 16'h3333);
    check("rr_owned", owned, 1);
    src_valid = 4'b0000;
    repeat (2) begin
      wait_tick();
      next();
    end
    check("rel3_owned", owned, 0);
    src_valid = 4'b0010;
    src_sample[16 +: 16] = 16'h5555;
    wait_tick();
    check("own1_ready", src_ready, 4'b0010);
    next();
    check("own1_owner", owner_id, 1);
    wait_tick();
    rst_n = 1'b0;
    src_valid = 4'b1010;
    #1;
    check("rstmid_ready", src_ready, 0);
    next();
    check("rstmid_owned", owned, 0);
    check("rstmid_sound", sound, 0);
    check("rstmid_sv", sound_valid, 0);
    rst_n = 1'b1;
    wait_tick();
    check("post_ready", src_ready, 4'b0010);
    next();
    check("post_owner", owner_id, 1);
    check("post_sound", sound, 16'h5555);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
